// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl - stall/flush sequencer for the 5-stage pipeline
// (IF, ID, EX, MEM, WB). Drives the enable/clear inputs of the pipeline
// registers. It resolves three kinds of event. A data-memory wait freezes
// the whole pipe. An EX-stage redirect squashes the wrong-path instructions.
// A load-use hazard inserts one bubble into EX.
//
// Optional feature macro: PIPE_HAZARD_PERF_EN. When it is defined, the
// stall-cycle and redirect performance counters are built. When it is not
// defined, both counter ports read 0 and no counter flops exist.
//
// Parameters:
//   REDIRECT_PENALTY  flush_id cycles per redirect (1..15)
//   MEM_TIMEOUT       longest memory freeze before forced release (0 = never)
//   CNT_W             performance counter width
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   id_rs1/id_rs2, id_uses_rs1/2     ID-stage source operands
//   ex_valid, ex_mem_read, ex_rd     EX-stage load information
//   ex_redirect                      EX resolved a taken branch or a jump
//   mem_req, mem_ready               MEM access handshake
//   stall_if/id/ex/mem               hold PC / IF/ID / ID/EX / EX/MEM
//   flush_id, flush_ex               clear IF/ID, ID/EX to a bubble
//   bubble_wb                        write a bubble into MEM/WB
//   mem_timeout                      one-cycle pulse on forced MEM release
//   perf_stall_cnt, perf_flush_cnt   performance counters
//
// state    | meaning
// RUN      | normal flow, load-use detection active
// MEM_WAIT | pipe frozen on a data memory access
// REDIRECT | extra flush_id cycles that cover fetch latency after a redirect

module pipe_hazard_ctrl #(
  parameter int REDIRECT_PENALTY = 1,
  parameter int MEM_TIMEOUT      = 64,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             bubble_wb,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REDIRECT = 2'd2} state_t;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [3:0] PEN_LOAD =
    4'((REDIRECT_PENALTY > 1) ? REDIRECT_PENALTY - 1 : 0);

  state_t            state, state_nxt, eff;
  logic              saved_redir, saved_redir_nxt;
  logic [3:0]        rcnt, rcnt_nxt;
  logic [WAIT_W-1:0] wcnt, wcnt_nxt, wcur;
  logic              mem_hold, timeout_hit, load_use, redirect_ok;

  always_comb begin
    // While frozen, the pre-freeze state decides what the release cycle does.
    if (state == MEM_WAIT) eff = saved_redir ? REDIRECT : RUN;
    else                   eff = state;
    // The number of freeze cycles already spent. It is 0 on the first frozen cycle.
    wcur        = (state == MEM_WAIT) ? wcnt : '0;
    mem_hold    = mem_req & ~mem_ready;
    timeout_hit = (MEM_TIMEOUT > 0) && mem_hold && (wcur == WAIT_LAST);
    load_use    = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                   (id_uses_rs2 & (id_rs2 == ex_rd)));

    stall_if        = 1'b0;
    stall_id        = 1'b0;
    stall_ex        = 1'b0;
    stall_mem       = 1'b0;
    flush_id        = 1'b0;
    flush_ex        = 1'b0;
    bubble_wb       = 1'b0;
    mem_timeout     = 1'b0;
    redirect_ok     = 1'b0;
    state_nxt       = state;
    saved_redir_nxt = saved_redir;
    rcnt_nxt        = rcnt;
    wcnt_nxt        = wcnt;

    if (mem_hold && !timeout_hit) begin
      stall_if        = 1'b1;
      stall_id        = 1'b1;
      stall_ex        = 1'b1;
      stall_mem       = 1'b1;
      bubble_wb       = 1'b1;
      state_nxt       = MEM_WAIT;
      saved_redir_nxt = (eff == REDIRECT);
      wcnt_nxt        = wcur + WAIT_W'(1);
    end else if (timeout_hit) begin
      // A forced release abandons any pending redirect penalty.
      mem_timeout     = 1'b1;
      state_nxt       = RUN;
      saved_redir_nxt = 1'b0;
      rcnt_nxt        = '0;
      wcnt_nxt        = '0;
    end else begin
      saved_redir_nxt = 1'b0;
      wcnt_nxt        = '0;
      if (ex_redirect) begin
        flush_id    = 1'b1;
        flush_ex    = 1'b1;
        redirect_ok = 1'b1;
        if (REDIRECT_PENALTY > 1) begin
          state_nxt = REDIRECT;
          rcnt_nxt  = PEN_LOAD;
        end else begin
          state_nxt = RUN;
          rcnt_nxt  = '0;
        end
      end else if (eff == REDIRECT) begin
        flush_id = 1'b1;
        if (rcnt <= 4'd1) begin
          state_nxt = RUN;
          rcnt_nxt  = '0;
        end else begin
          state_nxt = REDIRECT;
          rcnt_nxt  = rcnt - 4'd1;
        end
      end else begin
        state_nxt = RUN;
        if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
    end

    if (rst) begin
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      stall_mem   = 1'b0;
      flush_id    = 1'b1;
      flush_ex    = 1'b1;
      bubble_wb   = 1'b0;
      mem_timeout = 1'b0;
      redirect_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      saved_redir <= 1'b0;
      rcnt        <= '0;
      wcnt        <= '0;
    end else begin
      state       <= state_nxt;
      saved_redir <= saved_redir_nxt;
      rcnt        <= rcnt_nxt;
      wcnt        <= wcnt_nxt;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_if)    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect_ok) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (REDIRECT_PENALTY=3, MEM_TIMEOUT=8).
// The stimulus side drives one cycle at a time. It computes the expected
// outputs from a cycle-level reference model and queues them. A monitor then
// compares the DUT outputs against the queue on every falling edge.
module tb_pipe_hazard_ctrl;
  localparam int PEN = 3;
  localparam int TMO = 8;
  localparam int CW  = 32;

  logic clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read, ex_redirect;
  logic mem_req, mem_ready;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb, mem_timeout;
  logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;

  pipe_hazard_ctrl #(.REDIRECT_PENALTY(PEN), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .bubble_wb(bubble_wb), .mem_timeout(mem_timeout),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    logic [7:0]  outs;   // {s_if, s_id, s_ex, s_mem, f_id, f_ex, b_wb, tmo}
    logic [31:0] ps;
    logic [31:0] pf;
    bit          chkp;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state.
  int          pen_left = 0;   // flush_id-only cycles still owed
  int          waited   = 0;   // consecutive frozen cycles so far
  logic [31:0] m_stall  = 0;
  logic [31:0] m_flush  = 0;
  bit          perf_known = 0;

  task automatic drive(input string tag, input bit r, input bit mreq, input bit mrdy,
                       input bit redir, input bit exv, input bit exmr, input int exrd,
                       input int rs1, input int rs2, input bit u1, input bit u2);
    exp_t e;
    bit s_if, s_id, s_ex, s_mem, f_id, f_ex, b_wb, tmo, hazard;
    @(posedge clk);
    #1;
    rst = r; mem_req = mreq; mem_ready = mrdy; ex_redirect = redir;
    ex_valid = exv; ex_mem_read = exmr; ex_rd = 5'(exrd);
    id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_uses_rs1 = u1; id_uses_rs2 = u2;

    {s_if, s_id, s_ex, s_mem, f_id, f_ex, b_wb, tmo} = 8'b0;
    hazard = exv && exmr && (exrd != 0) && ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
`ifdef PIPE_HAZARD_PERF_EN
    e.ps = m_stall; e.pf = m_flush;
`else
    e.ps = 0; e.pf = 0;
`endif
    e.chkp = perf_known;
    if (r) begin
      f_id = 1; f_ex = 1;
      pen_left = 0; waited = 0; m_stall = 0; m_flush = 0; perf_known = 1;
    end else if (mreq && !mrdy) begin
      if (waited == TMO - 1) begin
        tmo = 1; waited = 0; pen_left = 0;
      end else begin
        {s_if, s_id, s_ex, s_mem, b_wb} = 5'b11111;
        waited++;
      end
    end else begin
      waited = 0;
      if (redir) begin
        f_id = 1; f_ex = 1; pen_left = PEN - 1; m_flush++;
      end else if (pen_left > 0) begin
        f_id = 1; pen_left--;
      end else if (hazard) begin
        s_if = 1; s_id = 1; f_ex = 1;
      end
    end
    if (s_if) m_stall++;
    e.tag  = tag;
    e.outs = {s_if, s_id, s_ex, s_mem, f_id, f_ex, b_wb, tmo};
    sbq.push_back(e);
  endtask

  task automatic quiet(input string tag);
    drive(tag, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic hold(input string tag, input bit redir, input bit lu);
    drive(tag, 0, 1, 0, redir, lu, lu, 5, 5, 0, lu, 0);
  endtask

  // Monitor: every cycle presents outputs, so one queued entry is consumed per falling edge.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        act = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb, mem_timeout};
        n_checks++;
        if (act !== e.outs) begin
          n_fail++;
          $display("FAIL %s outs got=%b expected=%b (t=%0t)", e.tag, act, e.outs, $time);
        end
        if (e.chkp) begin
          n_checks++;
          if (perf_stall_cnt !== e.ps) begin
            n_fail++;
            $display("FAIL %s perf_stall_cnt got=%0d expected=%0d", e.tag, perf_stall_cnt, e.ps);
          end
          n_checks++;
          if (perf_flush_cnt !== e.pf) begin
            n_fail++;
            $display("FAIL %s perf_flush_cnt got=%0d expected=%0d", e.tag, perf_flush_cnt, e.pf);
          end
        end
      end
    end
  end

  initial begin
    int burst;
    bit mreq, mrdy;
    rst = 1; mem_req = 0; mem_ready = 1; ex_redirect = 0; ex_valid = 0; ex_mem_read = 0;
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;

    drive("reset", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("reset", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    quiet("idle");

    drive("loaduse_rs1", 0, 0, 1, 0, 1, 1, 5, 5, 0, 1, 0);
    quiet("loaduse_bubble");
    drive("loaduse_rs2", 0, 0, 1, 0, 1, 1, 7, 1, 7, 1, 1);
    drive("x0_nostall", 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1);
    drive("unused_rs_nostall", 0, 0, 1, 0, 1, 1, 9, 9, 9, 0, 0);
    drive("not_load_nostall", 0, 0, 1, 0, 1, 0, 5, 5, 0, 1, 0);

    drive("redirect", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("redirect_pen", 0, 0, 1, 0, 1, 1, 5, 5, 0, 1, 0);
    quiet("redirect_pen");
    quiet("redirect_done");

    drive("redirect2", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("redirect2", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) quiet("redirect2_pen");

    hold("memwait", 0, 1);
    hold("memwait", 1, 0);
    hold("memwait", 1, 1);
    hold("memwait", 0, 0);
    drive("mem_release", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    quiet("idle");

    drive("redir_then_wait", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    hold("wait_in_redirect", 1, 0);
    hold("wait_in_redirect", 0, 0);
    drive("release_resume_pen", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    quiet("resume_pen");
    quiet("idle");

    for (int i = 0; i < 9; i++) hold("timeout", 0, 0);
    quiet("idle");

    hold("rst_in_memwait", 0, 0);
    hold("rst_in_memwait", 0, 0);
    drive("rst_in_memwait", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    quiet("after_rst");
    drive("rst_in_redirect", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("rst_in_redirect", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    quiet("after_rst");
    quiet("after_rst");

    // Perf scenario: 4 frozen cycles, 1 load-use, 2 redirects -> 5 stalls, 2 flushes.
    drive("perf_rst", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) hold("perf_wait", 0, 0);
    quiet("perf");
    drive("perf_lu", 0, 0, 1, 0, 1, 1, 3, 3, 0, 1, 0);
    quiet("perf");
    drive("perf_redir", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) quiet("perf");
    drive("perf_redir", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) quiet("perf_end");

    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 11);
      if (burst > 0) begin
        mreq = 1; mrdy = 0; burst--;
      end else begin
        mreq = 1'($urandom_range(0, 1)); mrdy = (mreq) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      drive("random", $urandom_range(0, 199) == 0, mreq, mrdy, $urandom_range(0, 7) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d entries left expected=0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
